// File: rtl/noc_params.sv
// +--------------------------------------------------------------------+
// | noc_params -- shared router dimensions and the output lock record  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

package noc_params;

  localparam int PORT_NUM = 5;
  localparam int VC_NUM   = 2;

  // Index width that never collapses to zero bits for single-entry dimensions.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int PORT_SIZE  = idx_width(PORT_NUM);
  localparam int VC_SIZE    = idx_width(VC_NUM);
  localparam int LOCK_IDX_W = 8;

  typedef struct packed {
    logic                  locked;
    logic [LOCK_IDX_W-1:0] in_port;
    logic [LOCK_IDX_W-1:0] vc;
  } lock_t;

  localparam lock_t LOCK_IDLE = '{locked: 1'b0, in_port: '0, vc: '0};

endpackage

`default_nettype wire

// File: rtl/round_robin_arbiter.sv
// +--------------------------------------------------------------------+
// | round_robin_arbiter -- one-hot round-robin grant, own pointer      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module round_robin_arbiter
  import noc_params::*;
#(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req_i,
  input  logic         grant_en_i,
  output logic [N-1:0] grant_o
);

  localparam int PW = idx_width(N);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;
  int            best_dist;

  // Winner is the requester closest to the pointer going upward with wrap.
  always_comb begin
    grant_o   = '0;
    ptr_d     = ptr_q;
    best_dist = N;
    for (int j = 0; j < N; j++) begin
      if (req_i[j] && (((j + N - int'(ptr_q)) % N) < best_dist)) begin
        best_dist = (j + N - int'(ptr_q)) % N;
      end
    end
    for (int j = 0; j < N; j++) begin
      if (req_i[j] && (((j + N - int'(ptr_q)) % N) == best_dist)) begin
        grant_o[j] = 1'b1;
        ptr_d      = PW'((j + 1) % N);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (grant_en_i) begin
      ptr_q <= ptr_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/vc_switch_allocator.sv
// +--------------------------------------------------------------------+
// | vc_switch_allocator -- separable input-first VC switch allocator   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module vc_switch_allocator #(
  parameter int   PORT_NUM    = noc_params::PORT_NUM,
  parameter int   VC_NUM      = noc_params::VC_NUM,
  parameter int   LOCK_PACKET = 1,
  localparam int  PORT_SIZE   = noc_params::idx_width(PORT_NUM),
  localparam int  VC_SIZE     = noc_params::idx_width(VC_NUM)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 switch_request_i [PORT_NUM][VC_NUM],
  input  logic [PORT_SIZE-1:0] out_port_i       [PORT_NUM][VC_NUM],
  input  logic [VC_SIZE-1:0]   down_vc_i        [PORT_NUM][VC_NUM],
  input  logic                 tail_i           [PORT_NUM][VC_NUM],
  input  logic                 on_off_i         [PORT_NUM][VC_NUM],
  output logic                 valid_sel_o      [PORT_NUM],
  output logic [VC_SIZE-1:0]   vc_sel_o         [PORT_NUM],
  output logic [PORT_SIZE-1:0] input_vc_sel_o   [PORT_NUM],
  output logic                 valid_flit_o     [PORT_NUM]
);

  import noc_params::*;

  lock_t                lock_q     [PORT_NUM];
  lock_t                lock_d     [PORT_NUM];
  logic [VC_NUM-1:0]    eligible   [PORT_NUM];
  logic [VC_NUM-1:0]    s1_grant   [PORT_NUM];
  logic [PORT_NUM-1:0]  s2_req     [PORT_NUM];
  logic [PORT_NUM-1:0]  s2_grant   [PORT_NUM];
  logic                 cand_valid [PORT_NUM];
  logic [VC_SIZE-1:0]   cand_vc    [PORT_NUM];
  logic [PORT_SIZE-1:0] cand_port  [PORT_NUM];
  logic                 in_locked  [PORT_NUM];
  logic [PORT_NUM-1:0]  in_adv;
  logic [PORT_NUM-1:0]  out_adv;

  // A locked output admits only its owner VC, and the owner's input offers only that VC.
  always_comb begin
    for (int i = 0; i < PORT_NUM; i++) begin
      for (int v = 0; v < VC_NUM; v++) begin
        eligible[i][v] = switch_request_i[i][v]
                         && (int'(out_port_i[i][v]) < PORT_NUM)
                         && (int'(down_vc_i[i][v]) < VC_NUM)
                         && on_off_i[out_port_i[i][v]][down_vc_i[i][v]];
        for (int o = 0; o < PORT_NUM; o++) begin
          if ((LOCK_PACKET != 0) && lock_q[o].locked
              && !((lock_q[o].in_port == LOCK_IDX_W'(i)) && (lock_q[o].vc == LOCK_IDX_W'(v)))
              && ((int'(out_port_i[i][v]) == o) || (lock_q[o].in_port == LOCK_IDX_W'(i)))) begin
            eligible[i][v] = 1'b0;
          end
        end
      end
    end
  end

  for (genvar gi = 0; gi < PORT_NUM; gi++) begin : g_stage1
    round_robin_arbiter #(.N(VC_NUM)) u_in_arb (
      .clk        (clk),
      .rst        (rst),
      .req_i      (eligible[gi]),
      .grant_en_i (in_adv[gi]),
      .grant_o    (s1_grant[gi])
    );
  end

  always_comb begin
    for (int i = 0; i < PORT_NUM; i++) begin
      cand_valid[i] = |s1_grant[i];
      cand_vc[i]    = '0;
      cand_port[i]  = '0;
      for (int v = 0; v < VC_NUM; v++) begin
        if (s1_grant[i][v]) begin
          cand_vc[i]   = VC_SIZE'(v);
          cand_port[i] = out_port_i[i][v];
        end
      end
    end
    for (int o = 0; o < PORT_NUM; o++) begin
      for (int i = 0; i < PORT_NUM; i++) begin
        s2_req[o][i] = cand_valid[i] && (int'(cand_port[i]) == o);
      end
    end
  end

  for (genvar go = 0; go < PORT_NUM; go++) begin : g_stage2
    round_robin_arbiter #(.N(PORT_NUM)) u_out_arb (
      .clk        (clk),
      .rst        (rst),
      .req_i      (s2_req[go]),
      .grant_en_i (out_adv[go]),
      .grant_o    (s2_grant[go])
    );
  end

  // Pointers freeze for the duration of a packet so fairness resumes after the tail.
  always_comb begin
    for (int i = 0; i < PORT_NUM; i++) begin
      valid_sel_o[i] = 1'b0;
      vc_sel_o[i]    = '0;
      in_adv[i]      = 1'b0;
      in_locked[i]   = 1'b0;
      for (int o = 0; o < PORT_NUM; o++) begin
        if ((LOCK_PACKET != 0) && lock_q[o].locked && (lock_q[o].in_port == LOCK_IDX_W'(i))) begin
          in_locked[i] = 1'b1;
        end
      end
    end
    for (int o = 0; o < PORT_NUM; o++) begin
      valid_flit_o[o]   = 1'b0;
      input_vc_sel_o[o] = '0;
      out_adv[o]        = 1'b0;
      lock_d[o]         = lock_q[o];
      for (int i = 0; i < PORT_NUM; i++) begin
        if (s2_grant[o][i] && !rst) begin
          valid_flit_o[o]   = 1'b1;
          input_vc_sel_o[o] = PORT_SIZE'(i);
          valid_sel_o[i]    = 1'b1;
          vc_sel_o[i]       = cand_vc[i];
          out_adv[o]        = !lock_q[o].locked;
          in_adv[i]         = !in_locked[i];
          if (LOCK_PACKET != 0) begin
            if (!lock_q[o].locked && !tail_i[i][cand_vc[i]]) begin
              lock_d[o] = '{locked: 1'b1, in_port: LOCK_IDX_W'(i), vc: LOCK_IDX_W'(cand_vc[i])};
            end else if (lock_q[o].locked && tail_i[i][cand_vc[i]]) begin
              lock_d[o] = LOCK_IDLE;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int o = 0; o < PORT_NUM; o++) begin
        lock_q[o] <= LOCK_IDLE;
      end
    end else begin
      for (int o = 0; o < PORT_NUM; o++) begin
        lock_q[o] <= lock_d[o];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vc_switch_allocator.sv
// +--------------------------------------------------------------------+
// | tb_vc_switch_allocator -- scoreboard bench with reference model    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_vc_switch_allocator;

  localparam int P = 5;
  localparam int V = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       sw_req [P][V];
  logic [2:0] op     [P][V];
  logic [1:0] dv     [P][V];
  logic       tl     [P][V];
  logic       oo     [P][V];
  logic       vs     [P];
  logic [1:0] vcs    [P];
  logic [2:0] ivs    [P];
  logic       vf     [P];

  vc_switch_allocator #(.PORT_NUM(P), .VC_NUM(V), .LOCK_PACKET(1)) dut (
    .clk              (clk),
    .rst              (rst),
    .switch_request_i (sw_req),
    .out_port_i       (op),
    .down_vc_i        (dv),
    .tail_i           (tl),
    .on_off_i         (oo),
    .valid_sel_o      (vs),
    .vc_sel_o         (vcs),
    .input_vc_sel_o   (ivs),
    .valid_flit_o     (vf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [P-1:0]   vs;
    logic [2*P-1:0] vc;
    logic [3*P-1:0] ivs;
    logic [P-1:0]   vf;
  } outv_t;

  typedef struct {
    outv_t exp;
    int    kind;
    int    o;
    bit    valid;
    int    inp;
    int    k;
    int    cyc;
  } item_t;

  item_t q[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int d_kind = 0, d_o = 0, d_in = 0, d_k = 0;
  bit d_valid = 1'b0;

  // Reference state: pointers and per-output lock owner.
  int m_in_ptr [P];
  int m_out_ptr[P];
  bit m_lk     [P];
  int m_lk_in  [P];
  int m_lk_vc  [P];
  int g_vc     [P];
  int g_in     [P];

  task automatic model_reset();
    for (int i = 0; i < P; i++) begin
      m_in_ptr[i] = 0; m_out_ptr[i] = 0; m_lk[i] = 0; m_lk_in[i] = 0; m_lk_vc[i] = 0;
      g_vc[i] = -1; g_in[i] = -1;
    end
  endtask

  function automatic bit elig(int i, int v);
    int o = int'(op[i][v]);
    int d = int'(dv[i][v]);
    if (!sw_req[i][v] || o >= P) return 1'b0;
    if (!oo[o][d]) return 1'b0;
    for (int x = 0; x < P; x++) begin
      if (m_lk[x] && !(m_lk_in[x] == i && m_lk_vc[x] == v) && (o == x || m_lk_in[x] == i))
        return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic outv_t model_eval();
    outv_t e = '0;
    int cand[P];
    for (int i = 0; i < P; i++) begin g_vc[i] = -1; g_in[i] = -1; end
    if (rst) return e;
    for (int i = 0; i < P; i++) begin
      cand[i] = -1;
      for (int k = 0; k < V; k++) begin
        if (cand[i] < 0 && elig(i, (m_in_ptr[i] + k) % V)) cand[i] = (m_in_ptr[i] + k) % V;
      end
    end
    for (int o = 0; o < P; o++) begin
      for (int k = 0; k < P; k++) begin
        int i = (m_out_ptr[o] + k) % P;
        if (g_in[o] < 0 && cand[i] >= 0 && int'(op[i][cand[i]]) == o) g_in[o] = i;
      end
      if (g_in[o] >= 0) begin
        g_vc[g_in[o]]          = cand[g_in[o]];
        e.vs[g_in[o]]          = 1'b1;
        e.vc[g_in[o]*2 +: 2]   = 2'(cand[g_in[o]]);
        e.vf[o]                = 1'b1;
        e.ivs[o*3 +: 3]        = 3'(g_in[o]);
      end
    end
    return e;
  endfunction

  task automatic model_commit();
    bit in_lk[P];
    if (rst) begin
      model_reset();
      return;
    end
    for (int i = 0; i < P; i++) begin
      in_lk[i] = 1'b0;
      for (int x = 0; x < P; x++) if (m_lk[x] && m_lk_in[x] == i) in_lk[i] = 1'b1;
    end
    for (int o = 0; o < P; o++) begin
      if (g_in[o] >= 0) begin
        int i = g_in[o];
        int v = g_vc[i];
        if (!in_lk[i]) m_in_ptr[i] = (v + 1) % V;
        if (!m_lk[o]) begin
          m_out_ptr[o] = (i + 1) % P;
          if (!tl[i][v]) begin m_lk[o] = 1'b1; m_lk_in[o] = i; m_lk_vc[o] = v; end
        end else if (tl[i][v]) begin
          m_lk[o] = 1'b0;
        end
      end
    end
  endtask

  function automatic outv_t pack_dut();
    outv_t g = '0;
    for (int i = 0; i < P; i++) begin
      g.vs[i] = vs[i]; g.vc[i*2 +: 2] = vcs[i]; g.ivs[i*3 +: 3] = ivs[i]; g.vf[i] = vf[i];
    end
    return g;
  endfunction

  task automatic step();
    item_t it;
    it.exp = model_eval();
    it.kind = d_kind; it.o = d_o; it.valid = d_valid; it.inp = d_in; it.k = d_k; it.cyc = cyc;
    q.push_back(it);
    d_kind = 0;
    @(posedge clk); #1;
    model_commit();
    cyc++;
  endtask

  task automatic expect_out(int o, bit valid, int inp);
    d_kind = 1; d_o = o; d_valid = valid; d_in = inp;
    step();
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < P; i++) begin
      for (int v = 0; v < V; v++) begin
        sw_req[i][v] = 1'b0; op[i][v] = '0; dv[i][v] = '0; tl[i][v] = 1'b0; oo[i][v] = 1'b1;
      end
    end
  endtask

  task automatic set_req(int i, int v, int o, int d, bit t);
    sw_req[i][v] = 1'b1; op[i][v] = 3'(o); dv[i][v] = 2'(d); tl[i][v] = t;
  endtask

  task automatic random_inputs();
    for (int i = 0; i < P; i++) begin
      for (int v = 0; v < V; v++) begin
        sw_req[i][v] = ($urandom_range(99) < 60);
        op[i][v]     = 3'($urandom_range(P - 1));
        dv[i][v]     = 2'($urandom_range(V - 1));
        tl[i][v]     = ($urandom_range(99) < 40);
        oo[i][v]     = ($urandom_range(99) < 80);
      end
    end
  endtask

  // Monitor: compares every presented output set against the queued expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        item_t it;
        outv_t got;
        bit    ok;
        it  = q.pop_front();
        got = pack_dut();
        total++;
        if (got !== it.exp) begin
          bad++;
          $display("FAIL model cyc=%0d got=%h exp=%h", it.cyc, got, it.exp);
        end
        if (it.kind == 1) begin
          total++;
          if (vf[it.o] !== it.valid || (it.valid && ivs[it.o] !== 3'(it.inp))) begin
            bad++;
            $display("FAIL plan cyc=%0d out=%0d got valid=%b in=%0d need valid=%b in=%0d",
                     it.cyc, it.o, vf[it.o], ivs[it.o], it.valid, it.inp);
          end
        end else if (it.kind == 2) begin
          total++;
          ok = 1'b1;
          for (int i = 0; i < P; i++) if (vs[i] !== 1'b1 || vcs[i] !== 2'(it.k)) ok = 1'b0;
          if (!ok) begin
            bad++;
            $display("FAIL fullload cyc=%0d got=%h need all inputs on vc %0d", it.cyc, got, it.k);
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    clear_inputs();
    model_reset();
    @(posedge clk); #1;

    // Reset forces outputs low even with a request present.
    set_req(0, 0, 0, 0, 1'b1);
    expect_out(0, 1'b0, 0);
    expect_out(0, 1'b0, 0);
    rst = 1'b0;

    // Contention on out 3 with single-flit packets.
    clear_inputs();
    set_req(0, 1, 3, 0, 1'b1);
    set_req(2, 0, 3, 0, 1'b1);
    expect_out(3, 1'b1, 0);
    expect_out(3, 1'b1, 2);
    expect_out(3, 1'b1, 0);
    expect_out(3, 1'b1, 2);

    // Downstream VC off, then on in the grant cycle.
    clear_inputs();
    oo[1][1] = 1'b0;
    set_req(4, 0, 1, 1, 1'b1);
    expect_out(1, 1'b0, 0);
    expect_out(1, 1'b0, 0);
    oo[1][1] = 1'b1;
    expect_out(1, 1'b1, 4);

    // Packet lock with a 2-cycle stall, then the competitor after the tail.
    clear_inputs();
    set_req(1, 0, 2, 0, 1'b0);
    set_req(3, 1, 2, 1, 1'b0);
    expect_out(2, 1'b1, 1);
    expect_out(2, 1'b1, 1);
    oo[2][0] = 1'b0;
    expect_out(2, 1'b0, 0);
    expect_out(2, 1'b0, 0);
    oo[2][0] = 1'b1;
    tl[1][0] = 1'b1;
    expect_out(2, 1'b1, 1);
    sw_req[1][0] = 1'b0;
    expect_out(2, 1'b1, 3);

    // Reset mid-packet drops the lock without a tail.
    rst = 1'b1;
    expect_out(2, 1'b0, 0);
    rst = 1'b0;
    clear_inputs();
    set_req(1, 0, 2, 0, 1'b0);
    set_req(3, 1, 2, 1, 1'b0);
    expect_out(2, 1'b1, 1);
    rst = 1'b1;
    expect_out(2, 1'b0, 0);
    rst = 1'b0;
    sw_req[1][0] = 1'b0;
    expect_out(2, 1'b1, 3);

    // Full load: every VC requests, outputs form a permutation per VC index.
    rst = 1'b1;
    step();
    rst = 1'b0;
    clear_inputs();
    for (int i = 0; i < P; i++) for (int v = 0; v < V; v++) set_req(i, v, (i + v) % P, v, 1'b1);
    for (int c = 0; c < 8; c++) begin
      d_kind = 2; d_k = c % V;
      step();
    end

    // Randomized traffic with occasional reset pulses.
    for (int c = 0; c < 400; c++) begin
      random_inputs();
      rst = ($urandom_range(99) < 2);
      step();
    end
    rst = 1'b0;

    @(negedge clk); #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d pending need=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vc_switch_allocator.md
# vc_switch_allocator

Parametrised per-VC switch allocator for the NoC router: arbitrates crossbar access among all (input port, virtual channel) pairs in one cycle using a separable input-first scheme with round-robin fairness at both stages. Drives the input-block VC/valid selects and the crossbar column selects. Adds downstream-VC-granular on/off gating and an optional wormhole packet lock that holds an output for one packet until its tail flit is granted. Sits between the input blocks and the crossbar, in the slot of the single-VC allocator.

## Interface
- `PORT_NUM`, default 5: router ports; input and output count.
- `VC_NUM`, default 2: virtual channels per input port; ≥1.
- `LOCK_PACKET`, default 1: 1 enables wormhole output lock; 0 arbitrates flit-by-flit.
- `clk` in 1: clock.
- `rst` in 1: asynchronous, active-high reset.
- `switch_request_i` in [PORT_NUM][VC_NUM]: input VC holds a flit requesting the switch.
- `out_port_i` in [PORT_NUM][VC_NUM] x PORT_SIZE: requested output port per input VC.
- `down_vc_i` in [PORT_NUM][VC_NUM] x VC_SIZE: allocated downstream VC per input VC.
- `tail_i` in [PORT_NUM][VC_NUM]: requesting flit is a tail (or head-tail).
- `on_off_i` in [PORT_NUM][VC_NUM]: downstream VC on/off credit, indexed [output][downstream VC]; 1 = may send.
- `valid_sel_o` out [PORT_NUM]: input port granted this cycle.
- `vc_sel_o` out [PORT_NUM] x VC_SIZE: granted VC per input port; 0 when not valid.
- `input_vc_sel_o` out [PORT_NUM] x PORT_SIZE: crossbar select per output, the winning input port; 0 when idle.
- `valid_flit_o` out [PORT_NUM]: output carries a flit this cycle.

## Operation
- Eligible(i,v) = `switch_request_i[i][v]` & `on_off_i[out_port_i[i][v]][down_vc_i[i][v]]` & not masked by a lock.
- Stage 1, per input i: round-robin among eligible VCs, starting at `in_ptr[i]`. Yields at most one candidate (i,v) per input.
- Stage 2, per output o: round-robin among inputs whose stage-1 candidate targets o, starting at `out_ptr[o]`.
- Grant (i,v)→o sets `valid_sel_o[i]`=1, `vc_sel_o[i]`=v, `valid_flit_o[o]`=1, `input_vc_sel_o[o]`=i.
- At most one grant per input and per output. A stage-1 winner losing stage 2 yields no grant for that input; no retry within the cycle.
- Pointer update only on grant: `in_ptr[i]` ← v+1 mod VC_NUM, `out_ptr[o]` ← i+1 mod PORT_NUM. Ungranted pointers hold.
- Lock, LOCK_PACKET=1: per output, state IDLE or LOCKED(i,v).
  - IDLE → LOCKED(i,v) on a grant to o with `tail_i`=0.
  - LOCKED(i,v) → IDLE on a grant of (i,v) with `tail_i`=1. A head-tail flit never locks.
  - While LOCKED(i,v): every other (i',v') targeting o is masked, and every other VC of input i is masked, so input i's stage 1 selects only v.
  - While locked, pointers of o and i do not advance.
- If the locked VC is off or not requesting, o stays idle and the lock holds.
- With LOCK_PACKET=0, no lock state exists.

## Timing
- Grants are combinational from inputs and current state: zero-cycle latency. The flit traverses the crossbar in the same cycle.
- Pointer and lock registers update on the rising `clk` edge following a grant.
- While `rst` is high, all outputs are forced to 0.
- Reset values:
  - all `in_ptr` and `out_ptr` = 0;
  - all locks = IDLE;
  - all outputs 0.
- Reset asserted mid-packet clears the lock immediately, with no tail required.
- `on_off_i` dropping in the grant cycle blocks that grant in the same cycle.
- Simultaneous lock release by tail and a new request in the next cycle: the new request is arbitrated normally in that next cycle.
- Indices wrap modulo PORT_NUM / VC_NUM. When VC_NUM=1, VC_SIZE is treated as width 1 and `vc_sel_o` is constant 0.

## Structure
- `noc_params` holds `PORT_NUM`, `VC_NUM`, `PORT_SIZE`=$clog2(PORT_NUM), `VC_SIZE`=$clog2(VC_NUM), and a lock-state typedef with fields `locked`, `in_port`, `vc`.
- Sub-module `round_robin_arbiter #(N)`:
  - inputs: request vector, grant-enable;
  - output: one-hot grant;
  - holds its own pointer, async active-high reset.
- Instantiated PORT_NUM times for stage 1 (N=VC_NUM) and PORT_NUM times for stage 2 (N=PORT_NUM).

## Test plan
- Contention, VC_NUM=2: input 0 VC1 and input 2 VC0 both request out 3 with heads, all on, LOCK_PACKET=0. Required grants: cycle 0 → input 0 (`input_vc_sel_o[3]`=0); cycle 1 → input 2; then alternating.
- Flow control: `on_off_i[1][1]`=0 while input 4 VC0 requests out 1 with `down_vc_i`=1. Required: no grant. Raise `on_off_i[1][1]` → grant in the same cycle.
- Packet lock: input 1 VC0 sends 3-flit packet (H,B,T) to out 2 while input 3 VC1 also requests out 2. Required: out 2 serves input 1 for 3 grant cycles, then input 3.
- Lock stall: drop `on_off_i` of the locked VC mid-packet for 2 cycles. Required: out 2 idle for those 2 cycles; input 3 not granted; packet resumes afterward.
- Reset mid-packet: assert `rst` after the head flit. Required: all outputs 0 at once; after release, input 3 is grantable on out 2 in the first cycle.
- Full load, PORT_NUM=5, VC_NUM=4: all 20 VCs request distinct-permutation outputs. Required: 5 grants every cycle; each VC granted once per 4 cycles.
